// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and constants for the SLC-3 SRAM access sequencer.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } sram_state_t;

    localparam int   DEFAULT_WAIT = 2;
    localparam logic CTRL_ON      = 1'b0;
    localparam logic CTRL_OFF     = 1'b1;

    // Chip is selected in every state that touches the SRAM.
    function automatic logic chip_selected(sram_state_t s);
        return (s == RD_STROBE) || (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
    endfunction

    function automatic logic bus_driven(sram_state_t s);
        return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// CPU-side memory port: single-cycle requests in, read data and ready/busy out.
interface sram_access_ctrl_if;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;

    modport master (output req_rd, req_wr, addr, wdata, be, input rdata, ready, busy);
    modport slave  (input req_rd, req_wr, addr, wdata, be, output rdata, ready, busy);
endinterface

// File: rtl/sram_access_ctrl_wait_timer.sv
// Strobe-width down-counter; zero marks the last cycle of a strobe.
module sram_wait_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [3:0] count;

    // Saturates at zero so a zero-length wait never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 4'd1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences CPU memory requests into active-low async SRAM strobes and owns the data bus.
//  state     | meaning
//  IDLE      | no access; requests sampled here only
//  RD_STROBE | CE/OE low for WAIT_CYCLES+1 cycles, data captured on last edge
//  WR_SETUP  | address and data driven, WE still high
//  WR_PULSE  | WE low for WAIT_CYCLES+1 cycles
//  WR_HOLD   | WE high, data still driven
//  DONE      | one-cycle ready pulse
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_access_ctrl_if.slave cpu,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              UB,
    output logic              LB,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [15:0]       Data
);
    sram_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q, rdata_q;
    logic [1:0]        be_q, be_nxt;
    logic              latch_acc, latch_wr, tmr_load, tmr_dec, tmr_zero, capture;
    logic              ready_q, busy_q, drive_q, sel_nxt;

    sram_wait_timer u_timer (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (tmr_load),
        .load_val (4'(WAIT_CYCLES)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        latch_acc = 1'b0;
        latch_wr  = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu.req_rd) begin
                    state_nxt = RD_STROBE;
                    latch_acc = 1'b1;
                    tmr_load  = 1'b1;
                end else if (cpu.req_wr) begin
                    state_nxt = WR_SETUP;
                    latch_acc = 1'b1;
                    latch_wr  = 1'b1;
                end
            end
            RD_STROBE: begin
                if (tmr_zero) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                tmr_load  = 1'b1;
            end
            WR_PULSE: begin
                if (tmr_zero)
                    state_nxt = WR_HOLD;
                else
                    tmr_dec = 1'b1;
            end
            WR_HOLD: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they change on the same edge as the state.
    assign be_nxt  = latch_acc ? cpu.be : be_q;
    assign sel_nxt = chip_selected(state_nxt);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
            CE      <= CTRL_OFF;
            OE      <= CTRL_OFF;
            WE      <= CTRL_OFF;
            UB      <= CTRL_OFF;
            LB      <= CTRL_OFF;
        end else begin
            state <= state_nxt;
            if (latch_acc) begin
                addr_q <= ADDR_W'(cpu.addr);
                be_q   <= cpu.be;
            end
            if (latch_wr)
                wdata_q <= cpu.wdata;
            if (capture)
                rdata_q <= Data;
            ready_q <= (state_nxt == DONE);
            busy_q  <= (state_nxt != IDLE);
            drive_q <= bus_driven(state_nxt);
            CE      <= sel_nxt ? CTRL_ON : CTRL_OFF;
            OE      <= (state_nxt == RD_STROBE) ? CTRL_ON : CTRL_OFF;
            WE      <= (state_nxt == WR_PULSE) ? CTRL_ON : CTRL_OFF;
            UB      <= sel_nxt ? ~be_nxt[1] : CTRL_OFF;
            LB      <= sel_nxt ? ~be_nxt[0] : CTRL_OFF;
        end
    end

    assign Data      = drive_q ? wdata_q : 'z;
    assign ADDR      = addr_q;
    assign cpu.rdata = rdata_q;
    assign cpu.ready = ready_q;
    assign cpu.busy  = busy_q;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: default-wait and zero-wait builds against a behavioural SRAM.
module tb_sram_access_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_rd, req_wr;
    logic [15:0] addr, wdata;
    logic [1:0]  be;
    int          total = 0;
    int          bad   = 0;

    sram_access_ctrl_if if2 ();
    sram_access_ctrl_if if0 ();

    assign if2.req_rd = req_rd & ~sel;
    assign if2.req_wr = req_wr & ~sel;
    assign if0.req_rd = req_rd & sel;
    assign if0.req_wr = req_wr & sel;
    assign if2.addr = addr;
    assign if0.addr = addr;
    assign if2.wdata = wdata;
    assign if0.wdata = wdata;
    assign if2.be = be;
    assign if0.be = be;

    logic        ce2, oe2, we2, ub2, lb2, ce0, oe0, we0, ub0, lb0;
    logic [19:0] adr2, adr0;
    wire  [15:0] bus2, bus0;

    sram_access_ctrl #(.WAIT_CYCLES(2), .ADDR_W(20)) dut2 (
        .Clk(clk), .Reset(rst_n), .cpu(if2), .CE(ce2), .OE(oe2), .WE(we2),
        .UB(ub2), .LB(lb2), .ADDR(adr2), .Data(bus2));
    sram_access_ctrl #(.WAIT_CYCLES(0), .ADDR_W(20)) dut0 (
        .Clk(clk), .Reset(rst_n), .cpu(if0), .CE(ce0), .OE(oe0), .WE(we0),
        .UB(ub0), .LB(lb0), .ADDR(adr0), .Data(bus0));

    // Behavioural async SRAMs: drive while CE/OE low, store on the rising edge of WE.
    logic [15:0] mem2 [256];
    logic [15:0] mem0 [256];
    assign bus2 = (!ce2 && !oe2 && we2) ? mem2[adr2[7:0]] : 'z;
    assign bus0 = (!ce0 && !oe0 && we0) ? mem0[adr0[7:0]] : 'z;
    always @(posedge we2) if (!ce2) begin
        if (!ub2) mem2[adr2[7:0]][15:8] = bus2[15:8];
        if (!lb2) mem2[adr2[7:0]][7:0]  = bus2[7:0];
    end
    always @(posedge we0) if (!ce0) begin
        if (!ub0) mem0[adr0[7:0]][15:8] = bus0[15:8];
        if (!lb0) mem0[adr0[7:0]][7:0]  = bus0[7:0];
    end

    // Reference: expected memory contents and latencies from the access rules.
    logic [15:0] ref2 [256];
    logic [15:0] ref0 [256];

    logic        s_ready, s_busy, s_ce, s_oe, s_we, s_ub, s_lb;
    logic [15:0] s_rdata;
    logic [19:0] s_addr;
    assign s_ready = sel ? if0.ready : if2.ready;
    assign s_busy  = sel ? if0.busy  : if2.busy;
    assign s_rdata = sel ? if0.rdata : if2.rdata;
    assign s_ce = sel ? ce0 : ce2;
    assign s_oe = sel ? oe0 : oe2;
    assign s_we = sel ? we0 : we2;
    assign s_ub = sel ? ub0 : ub2;
    assign s_lb = sel ? lb0 : lb2;
    assign s_addr = sel ? adr0 : adr2;

    int we_cnt = 0, oe_cnt = 0, ube_err = 0;
    always @(negedge clk) begin
        if (!s_we) we_cnt++;
        if (!s_oe) oe_cnt++;
        if ((!s_we || !s_oe) && (s_ub || s_lb)) ube_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int wait_of();
        return sel ? 0 : 2;
    endfunction

    task automatic wait_ready(output int lat);
        lat = 0;
        @(negedge clk);
        while (!s_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        int lat, w0;
        w0 = we_cnt;
        addr = a; wdata = d; req_wr = 1'b1;
        @(posedge clk);
        #1 req_wr = 1'b0;
        addr = 16'($urandom); wdata = 16'($urandom);
        wait_ready(lat);
        chk("wr_lat", lat, wait_of() + 3);
        chk("we_low", we_cnt - w0, wait_of() + 1);
        chk("wr_addr", s_addr, {4'h0, a});
        if (sel) ref0[a[7:0]] = d; else ref2[a[7:0]] = d;
        @(negedge clk);
        chk("wr_ready_pulse", s_ready, 1'b0);
    endtask

    task automatic do_read(input logic [15:0] a, input bit both);
        int lat, w0, o0;
        w0 = we_cnt; o0 = oe_cnt;
        addr = a; req_rd = 1'b1;
        if (both) begin req_wr = 1'b1; wdata = 16'($urandom); end
        @(posedge clk);
        #1 req_rd = 1'b0; req_wr = 1'b0;
        addr = 16'($urandom);
        wait_ready(lat);
        chk("rd_lat", lat, wait_of() + 1);
        chk("rd_data", s_rdata, sel ? ref0[a[7:0]] : ref2[a[7:0]]);
        chk("oe_low", oe_cnt - o0, wait_of() + 1);
        chk("rd_no_we", we_cnt - w0, 0);
        @(negedge clk);
        chk("rd_ready_pulse", s_ready, 1'b0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) begin
            mem2[i] = '0; mem0[i] = '0; ref2[i] = '0; ref0[i] = '0;
        end
        rst_n = 1'b0; sel = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        addr = '0; wdata = '0; be = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {ce2, oe2, we2, ub2, lb2}, 5'b11111);
        chk("rst_flags", {if2.ready, if2.busy}, 2'b00);
        chk("rst_rdata", if2.rdata, 16'h0000);
        chk("rst_addr", adr2, 20'h0);
        chk("rst_drive", dut2.drive_q, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        do_write(16'h0003, 16'hABCD);
        do_read(16'h0003, 1'b0);
        do_write(16'h0010, 16'hBEEF);
        do_read(16'h0010, 1'b1);

        // Held read request: a new access starts after each DONE/IDLE pair.
        do_write(16'h0000, 16'hDEAD);
        do_write(16'h0001, 16'hC0FF);
        addr = 16'h0000; req_rd = 1'b1;
        wait_ready(lat);
        chk("b2b_lat", lat, wait_of() + 1);
        chk("b2b_data0", s_rdata, 16'hDEAD);
        addr = 16'h0001;
        wait_ready(lat);
        chk("b2b_gap", lat + 1, (wait_of() + 1) + 2);
        chk("b2b_data1", s_rdata, 16'hC0FF);
        req_rd = 1'b0;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) do_write(a, 16'($urandom));
            else do_read(a, 1'b0);
        end

        // Reset asserted in the middle of the write pulse.
        addr = 16'h00F0; wdata = 16'h5555; req_wr = 1'b1;
        @(posedge clk);
        #1 req_wr = 1'b0;
        @(posedge clk);
        #2 chk("we_before_rst", we2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_ce", {we2, ce2, oe2}, 3'b111);
        chk("rst_mid_drive", dut2.drive_q, 1'b0);
        chk("rst_mid_flags", {if2.ready, if2.busy}, 2'b00);
        chk("rst_mid_addr", adr2, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_rdata", if2.rdata, 16'h0000);
        do_read(16'h0003, 1'b0);

        sel = 1'b1;
        @(negedge clk);
        do_write(16'h0003, 16'h1234);
        do_read(16'h0003, 1'b0);
        do_read(16'h0007, 1'b0);

        chk("ub_lb_during_strobe", ube_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
